// File: rtl/mem_access_ctrl_if.sv
// ============================================================================
// Module   : mem_access_ctrl_if
// Purpose  : SRAM-like data bus between the MEM-stage controller and memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface mem_access_ctrl_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module   : mem_access_ctrl
// Purpose  : MEM-stage load/store sequencer for an SRAM-like bus.
//            Optional macro MEM_ADDR_CHECK_EN enables alignment exceptions.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl (
    input  wire logic          clk,
    input  wire logic          resetn,
    input  wire logic          mem_validM,
    input  wire logic [7:0]    alucontrolM,
    input  wire logic [31:0]   aluoutM,
    input  wire logic [31:0]   writedataM,
    input  wire logic          flushM,
    input  wire logic          mem_advance,
    mem_access_ctrl_if.master  bus,
    output logic [31:0]        lwresultM,
    output logic               adelM,
    output logic               adesM,
    output logic [31:0]        badaddrM,
    output logic               mem_stall
);

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_CANCEL = 3'd4
    } state_t;

    state_t      state_q;
    logic [31:0] lwresult_q;

    logic        w_is_load;
    logic        w_is_store;
    logic [1:0]  w_size;
    logic        w_adel;
    logic        w_ades;
    logic [31:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_access;
    logic        w_issue;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = 2'd0;
        case (alucontrolM)
            EXE_LB_OP, EXE_LBU_OP: begin w_is_load  = 1'b1; w_size = 2'd0; end
            EXE_LH_OP, EXE_LHU_OP: begin w_is_load  = 1'b1; w_size = 2'd1; end
            EXE_LW_OP:             begin w_is_load  = 1'b1; w_size = 2'd2; end
            EXE_SB_OP:             begin w_is_store = 1'b1; w_size = 2'd0; end
            EXE_SH_OP:             begin w_is_store = 1'b1; w_size = 2'd1; end
            EXE_SW_OP:             begin w_is_store = 1'b1; w_size = 2'd2; end
            default:               ;
        endcase
    end

`ifdef MEM_ADDR_CHECK_EN
    logic w_misalign;
    assign w_misalign = ((w_size == 2'd1) & aluoutM[0]) |
                        ((w_size == 2'd2) & (|aluoutM[1:0]));
    assign w_adel = mem_validM & w_is_load  & w_misalign;
    assign w_ades = mem_validM & w_is_store & w_misalign;
    assign w_addr = aluoutM;
`else
    // Without alignment checking the bus always sees a naturally aligned address.
    assign w_adel = 1'b0;
    assign w_ades = 1'b0;
    assign w_addr = {aluoutM[31:2],
                     (w_size == 2'd2) ? 2'b00 :
                     (w_size == 2'd1) ? {aluoutM[1], 1'b0} : aluoutM[1:0]};
`endif

    always_comb begin
        case (w_size)
            2'd0:    w_wdata = {4{writedataM[7:0]}};
            2'd1:    w_wdata = {2{writedataM[15:0]}};
            default: w_wdata = writedataM;
        endcase
    end

    assign w_access = mem_validM & (w_is_load | w_is_store) & ~w_adel & ~w_ades & ~flushM;
    assign w_issue  = ((state_q == S_IDLE) & w_access) | ((state_q == S_REQ) & ~flushM);

    assign bus.data_req   = resetn & w_issue;
    assign bus.data_wr    = w_is_store;
    assign bus.data_size  = w_size;
    assign bus.data_addr  = w_addr;
    assign bus.data_wdata = w_wdata;

    assign mem_stall = resetn & (((state_q == S_IDLE) & w_access) |
                                 (state_q == S_REQ) | (state_q == S_WAIT));
    assign adelM     = resetn & w_adel;
    assign adesM     = resetn & w_ades;
    assign badaddrM  = (adelM | adesM) ? aluoutM : 32'd0;
    assign lwresultM = lwresult_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            lwresult_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE, S_REQ: begin
                    if (!w_issue) begin
                        state_q <= S_IDLE;
                    end else if (bus.data_addr_ok) begin
                        if (bus.data_data_ok) begin
                            state_q <= S_DONE;
                            if (w_is_load) lwresult_q <= bus.data_rdata;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else begin
                        state_q <= S_REQ;
                    end
                end
                S_WAIT: begin
                    // A beat arriving alongside the flush is already consumed.
                    if (flushM) begin
                        state_q <= bus.data_data_ok ? S_IDLE : S_CANCEL;
                    end else if (bus.data_data_ok) begin
                        state_q <= S_DONE;
                        if (w_is_load) lwresult_q <= bus.data_rdata;
                    end
                end
                S_DONE: begin
                    if (flushM | mem_advance) state_q <= S_IDLE;
                end
                S_CANCEL: begin
                    if (bus.data_data_ok) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module   : tb_mem_access_ctrl
// Purpose  : Directed vector table plus hand sequences for mem_access_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] NONMEM_OP  = 8'h20;

    logic        clk;
    logic        resetn;
    logic        mem_validM;
    logic [7:0]  alucontrolM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic        flushM;
    logic        mem_advance;
    logic [31:0] lwresultM;
    logic        adelM;
    logic        adesM;
    logic [31:0] badaddrM;
    logic        mem_stall;

    mem_access_ctrl_if bus ();

    mem_access_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .mem_validM  (mem_validM),
        .alucontrolM (alucontrolM),
        .aluoutM     (aluoutM),
        .writedataM  (writedataM),
        .flushM      (flushM),
        .mem_advance (mem_advance),
        .bus         (bus),
        .lwresultM   (lwresultM),
        .adelM       (adelM),
        .adesM       (adesM),
        .badaddrM    (badaddrM),
        .mem_stall   (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        valid;
        logic [7:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        req;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic        adel;
        logic        ades;
        logic [31:0] lw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] op, input logic [31:0] a,
                         input logic aok, input logic dok);
        mem_validM        = v;
        alucontrolM       = op;
        aluoutM           = a;
        bus.data_addr_ok  = aok;
        bus.data_data_ok  = dok;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            valid op          addr          wd            rdata         req  wr   sz    eaddr         ewdata        adel ades lw
        vecs[0]  = '{1'b1, EXE_LW_OP,  32'h0000_1000, 32'h1122_3344, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'd2, 32'h0000_1000, 32'h0,        1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[1]  = '{1'b1, EXE_SB_OP,  32'h0000_1003, 32'h0000_00A5, 32'h0,         1'b1, 1'b1, 2'd0, 32'h0000_1003, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, EXE_SH_OP,  32'h0000_2002, 32'h0000_BEEF, 32'h0,         1'b1, 1'b1, 2'd1, 32'h0000_2002, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, EXE_SW_OP,  32'h0000_3004, 32'hCAFE_F00D, 32'h0,         1'b1, 1'b1, 2'd2, 32'h0000_3004, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hDEAD_BEEF};
`ifdef MEM_ADDR_CHECK_EN
        vecs[4]  = '{1'b1, EXE_LH_OP,  32'h0000_2001, 32'h0,         32'h0000_ABCD, 1'b0, 1'b0, 2'd1, 32'h0,         32'h0,         1'b1, 1'b0, 32'hDEAD_BEEF};
`else
        vecs[4]  = '{1'b1, EXE_LH_OP,  32'h0000_2001, 32'h0,         32'h0000_ABCD, 1'b1, 1'b0, 2'd1, 32'h0000_2000, 32'h0,         1'b0, 1'b0, 32'h0000_ABCD};
`endif
        vecs[5]  = '{1'b1, EXE_LBU_OP, 32'h0000_4001, 32'h0,         32'h0000_0055, 1'b1, 1'b0, 2'd0, 32'h0000_4001, 32'h0,         1'b0, 1'b0, 32'h0000_0055};
        vecs[6]  = '{1'b1, EXE_LHU_OP, 32'h0000_4006, 32'h0,         32'h0000_9876, 1'b1, 1'b0, 2'd1, 32'h0000_4006, 32'h0,         1'b0, 1'b0, 32'h0000_9876};
`ifdef MEM_ADDR_CHECK_EN
        vecs[7]  = '{1'b1, EXE_LW_OP,  32'h0000_5002, 32'h0,         32'h1111_0000, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b1, 1'b0, 32'h0000_9876};
        vecs[8]  = '{1'b1, EXE_SW_OP,  32'h0000_6001, 32'h0102_0304, 32'h0,         1'b0, 1'b1, 2'd2, 32'h0,         32'h0,         1'b0, 1'b1, 32'h0000_9876};
`else
        vecs[7]  = '{1'b1, EXE_LW_OP,  32'h0000_5002, 32'h0,         32'h1111_0000, 1'b1, 1'b0, 2'd2, 32'h0000_5000, 32'h0,         1'b0, 1'b0, 32'h1111_0000};
        vecs[8]  = '{1'b1, EXE_SW_OP,  32'h0000_6001, 32'h0102_0304, 32'h0,         1'b1, 1'b1, 2'd2, 32'h0000_6000, 32'h0102_0304, 1'b0, 1'b0, 32'h1111_0000};
`endif
        vecs[9]  = '{1'b1, EXE_LB_OP,  32'h0000_7002, 32'h0,         32'h0000_0080, 1'b1, 1'b0, 2'd0, 32'h0000_7002, 32'h0,         1'b0, 1'b0, 32'h0000_0080};
        vecs[10] = '{1'b1, NONMEM_OP,  32'h0000_1000, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 2'd0, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0080};
        vecs[11] = '{1'b0, EXE_LW_OP,  32'h0000_1000, 32'h0,         32'hFFFF_FFFF, 1'b0, 1'b0, 2'd2, 32'h0,         32'h0,         1'b0, 1'b0, 32'h0000_0080};

        // Reset with a misaligned load presented: everything must stay quiet.
        resetn = 1'b0; flushM = 1'b0; mem_advance = 1'b0;
        writedataM = 32'h0; bus.data_rdata = 32'h0;
        drive(1'b1, EXE_LH_OP, 32'h0000_2001, 1'b0, 1'b0);
        #3;
        chk("rst_lw",     lwresultM,     32'h0);
        chk("rst_req",    bus.data_req,  1'b0);
        chk("rst_stall",  mem_stall,     1'b0);
        chk("rst_adel",   adelM,         1'b0);
        chk("rst_badaddr", badaddrM,     32'h0);
        step();
        mem_validM = 1'b0;
        step();
        resetn = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            writedataM     = vecs[i].wd;
            bus.data_rdata = vecs[i].rdata;
            drive(vecs[i].valid, vecs[i].op, vecs[i].addr, 1'b1, 1'b1);
            #1;
            chk($sformatf("v%0d_req", i),   bus.data_req, vecs[i].req);
            chk($sformatf("v%0d_stall", i), mem_stall,    vecs[i].req);
            chk($sformatf("v%0d_adel", i),  adelM,        vecs[i].adel);
            chk($sformatf("v%0d_ades", i),  adesM,        vecs[i].ades);
            chk($sformatf("v%0d_bad", i),   badaddrM,
                (vecs[i].adel | vecs[i].ades) ? vecs[i].addr : 32'h0);
            if (vecs[i].req) begin
                chk($sformatf("v%0d_wr", i),   bus.data_wr,   vecs[i].wr);
                chk($sformatf("v%0d_size", i), bus.data_size, vecs[i].size);
                chk($sformatf("v%0d_addr", i), bus.data_addr, vecs[i].eaddr);
                if (vecs[i].wr) chk($sformatf("v%0d_wdata", i), bus.data_wdata, vecs[i].ewdata);
            end
            step();
            drive(1'b0, vecs[i].op, vecs[i].addr, 1'b0, 1'b0);
            mem_advance = 1'b1;
            step();
            mem_advance = 1'b0;
            #1;
            chk($sformatf("v%0d_lw", i), lwresultM, vecs[i].lw);
        end

        // LW: addr_ok in cycle 0, data_ok in cycle 2, DONE in cycle 3.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b1, 1'b0);
        #1; chk("a_c0_req", bus.data_req, 1'b1); chk("a_c0_stall", mem_stall, 1'b1);
        step();
        bus.data_addr_ok = 1'b0;
        #1; chk("a_c1_stall", mem_stall, 1'b1); chk("a_c1_req", bus.data_req, 1'b0);
        step();
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
        #1; chk("a_c2_stall", mem_stall, 1'b1);
        step();
        bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
        #1; chk("a_c3_stall", mem_stall, 1'b0); chk("a_c3_lw", lwresultM, 32'hDEAD_BEEF);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_validM = 1'b0;

        // SB with addr_ok held off for three cycles.
        writedataM = 32'h0000_00A5;
        drive(1'b1, EXE_SB_OP, 32'h0000_1003, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) bus.data_addr_ok = 1'b1;
            #1;
            chk($sformatf("b_c%0d_req", c),   bus.data_req,   1'b1);
            chk($sformatf("b_c%0d_addr", c),  bus.data_addr,  32'h0000_1003);
            chk($sformatf("b_c%0d_wdata", c), bus.data_wdata, 32'hA5A5_A5A5);
            chk($sformatf("b_c%0d_size", c),  bus.data_size,  2'd0);
            chk($sformatf("b_c%0d_wr", c),    bus.data_wr,    1'b1);
            step();
        end
        bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b1; bus.data_rdata = 32'h7777_7777;
        #1; chk("b_wait_stall", mem_stall, 1'b1);
        step();
        bus.data_data_ok = 1'b0;
        #1; chk("b_done_stall", mem_stall, 1'b0); chk("b_lw_kept", lwresultM, 32'hDEAD_BEEF);
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0; mem_validM = 1'b0;

        // Flush in WAIT: CANCEL swallows the late beat and issues nothing.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b1, 1'b0);
        #1; chk("c_req", bus.data_req, 1'b1);
        step();
        bus.data_addr_ok = 1'b0; flushM = 1'b1;
        #1; chk("c_wait_stall", mem_stall, 1'b1);
        step();
        flushM = 1'b0;
        drive(1'b1, EXE_LW_OP, 32'h0000_2000, 1'b1, 1'b0);
        #1; chk("c_cancel_req", bus.data_req, 1'b0); chk("c_cancel_stall", mem_stall, 1'b0);
        step();
        drive(1'b0, EXE_LW_OP, 32'h0000_2000, 1'b0, 1'b1);
        bus.data_rdata = 32'h1234_5678;
        #1; chk("c_beat_req", bus.data_req, 1'b0);
        step();
        bus.data_data_ok = 1'b0;
        #1; chk("c_lw_kept", lwresultM, 32'hDEAD_BEEF);
        mem_validM = 1'b1;
        #1; chk("c_idle_req", bus.data_req, 1'b1);
        mem_validM = 1'b0;

        // DONE holds through three stalled cycles, never reissuing.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b1, 1'b1);
        bus.data_rdata = 32'h0BAD_F00D;
        #1; chk("d_req", bus.data_req, 1'b1);
        step();
        bus.data_data_ok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("d_hold%0d_req", c),   bus.data_req, 1'b0);
            chk($sformatf("d_hold%0d_stall", c), mem_stall,    1'b0);
            step();
        end
        mem_advance = 1'b1;
        step();
        mem_advance = 1'b0;
        drive(1'b0, EXE_LW_OP, 32'h0000_1000, 1'b0, 1'b0);
        #1; chk("d_lw", lwresultM, 32'h0BAD_F00D);
        mem_validM = 1'b1;
        #1; chk("d_idle_req", bus.data_req, 1'b1);
        mem_validM = 1'b0;

        // Flush in REQ drops the request and returns to IDLE.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b0, 1'b0);
        #1;
        step();
        flushM = 1'b1;
        #1; chk("e_flush_req", bus.data_req, 1'b0);
        step();
        flushM = 1'b0; alucontrolM = NONMEM_OP;
        #1; chk("e_idle_req", bus.data_req, 1'b0); chk("e_idle_stall", mem_stall, 1'b0);
        mem_validM = 1'b0;

        // Flush in DONE returns to IDLE.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b1, 1'b1);
        #1;
        step();
        drive(1'b0, EXE_LW_OP, 32'h0000_1000, 1'b0, 1'b0);
        flushM = 1'b1;
        step();
        flushM = 1'b0; mem_validM = 1'b1;
        #1; chk("f_idle_req", bus.data_req, 1'b1);
        mem_validM = 1'b0;

        // Reset mid-WAIT, then a stray data_ok.
        drive(1'b1, EXE_LW_OP, 32'h0000_1000, 1'b1, 1'b0);
        #1;
        step();
        bus.data_addr_ok = 1'b0;
        resetn = 1'b0;
        #1;
        chk("g_rst_lw",    lwresultM,    32'h0);
        chk("g_rst_stall", mem_stall,    1'b0);
        chk("g_rst_req",   bus.data_req, 1'b0);
        step();
        resetn = 1'b1; mem_validM = 1'b0;
        bus.data_data_ok = 1'b1; bus.data_rdata = 32'hAAAA_5555;
        #1; chk("g_late_stall", mem_stall, 1'b0); chk("g_late_req", bus.data_req, 1'b0);
        step();
        bus.data_data_ok = 1'b0;
        #1; chk("g_lw", lwresultM, 32'h0);
        mem_validM = 1'b1;
        #1; chk("g_idle_req", bus.data_req, 1'b1);
        mem_validM = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
